ca_seq_checker: RTL and testbench

CA_SEQ_CHECKER -- requirements
Module: ca_seq_checker

---
 rtl/ca_pkg.sv | 18 +
 rtl/ca_seq_checker_if.sv | 25 ++
 rtl/ca_rule_step.sv | 17 +
 rtl/ca_seq_checker.sv | 93 +++++++++
 tb/tb_ca_seq_checker.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ca_pkg.sv
// Shared types, widths and rule lookup for the cellular-automaton sequence checker.
package ca_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int ERR_CNT_W  = 16;
    localparam int BEAT_CNT_W = 32;

    // Elementary CA rule lookup: nbh is {left, centre, right}.
    function automatic logic rule_bit(input logic [7:0] rule, input logic [2:0] nbh);
        return rule[nbh];
    endfunction

endpackage

// File: rtl/ca_seq_checker_if.sv
// Stimulus/result bundle between a random-word source and the sequence checker.
interface ca_seq_checker_if #(
    parameter int ARRAY_WIDTH = 11,
    parameter int N           = 10
);
    logic [ARRAY_WIDTH-1:0]          i_seed;
    logic                            i_start;
    logic                            i_valid;
    logic [N-1:0]                    i_rn;
    logic                            o_locked;
    logic                            o_err;
    logic [ca_pkg::ERR_CNT_W-1:0]    o_err_cnt;
    logic [ca_pkg::BEAT_CNT_W-1:0]   o_beat_cnt;
    logic [N-1:0]                    o_first_fail;

    modport master (
        output i_seed, i_start, i_valid, i_rn,
        input  o_locked, o_err, o_err_cnt, o_beat_cnt, o_first_fail
    );

    modport slave (
        input  i_seed, i_start, i_valid, i_rn,
        output o_locked, o_err, o_err_cnt, o_beat_cnt, o_first_fail
    );
endinterface

// File: rtl/ca_rule_step.sv
// One combinational generation of an elementary cellular automaton on a ring.
module ca_rule_step
    import ca_pkg::*;
#(
    parameter int          ARRAY_WIDTH = 11,
    parameter logic [7:0]  RULE        = 8'd30
) (
    input  logic [ARRAY_WIDTH-1:0] cur,
    output logic [ARRAY_WIDTH-1:0] nxt
);
    // Left neighbour is the next-higher index, right is the next-lower, wrapping.
    for (genvar i = 0; i < ARRAY_WIDTH; i++) begin : g_cell
        localparam int LEFT  = (i + 1) % ARRAY_WIDTH;
        localparam int RIGHT = (i + ARRAY_WIDTH - 1) % ARRAY_WIDTH;
        assign nxt[i] = rule_bit(RULE, {cur[LEFT], cur[i], cur[RIGHT]});
    end
endmodule

// File: rtl/ca_seq_checker.sv
// Checks a received random-word stream against a local CA generator; tracks lock and errors.
module ca_seq_checker
    import ca_pkg::*;
#(
    parameter int          ARRAY_WIDTH = 11,
    parameter logic [7:0]  RULE        = 8'd30,
    parameter int          N           = 10,
    parameter int          LOCATION    = ARRAY_WIDTH / 2,
    parameter int          LOCK_LEN    = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    ca_seq_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_LEN + 1);

    state_t                  state;
    logic [ARRAY_WIDTH-1:0]  grid;
    logic [ARRAY_WIDTH-1:0]  grid_nxt;
    // Only the upper N-1 bits of E survive a shift, so bit 0 is never stored.
    logic [N-2:0]            exp_hi;
    logic [N-1:0]            exp_nxt;
    logic [MW-1:0]           match_cnt;
    logic                    fail_seen;
    logic                    beat;
    logic                    hit;

    ca_rule_step #(
        .ARRAY_WIDTH (ARRAY_WIDTH),
        .RULE        (RULE)
    ) u_step (
        .cur (grid),
        .nxt (grid_nxt)
    );

    assign exp_nxt = {grid[LOCATION], exp_hi};
    assign beat    = bus.i_valid && !bus.i_start && (state != ST_IDLE);
    assign hit     = (bus.i_rn == exp_nxt);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state            <= ST_IDLE;
            grid             <= '0;
            exp_hi           <= '0;
            match_cnt        <= '0;
            fail_seen        <= 1'b0;
            bus.o_locked     <= 1'b0;
            bus.o_err        <= 1'b0;
            bus.o_err_cnt    <= '0;
            bus.o_beat_cnt   <= '0;
            bus.o_first_fail <= '0;
        end else begin
            bus.o_err <= 1'b0;
            if (bus.i_start) begin
                state            <= ST_ACQ;
                grid             <= bus.i_seed;
                exp_hi           <= '0;
                match_cnt        <= '0;
                fail_seen        <= 1'b0;
                bus.o_locked     <= 1'b0;
                bus.o_err_cnt    <= '0;
                bus.o_beat_cnt   <= '0;
                bus.o_first_fail <= '0;
            end else if (beat) begin
                grid           <= grid_nxt;
                exp_hi         <= exp_nxt[N-1:1];
                bus.o_beat_cnt <= bus.o_beat_cnt + 1'b1;
                if (hit) begin
                    if (state == ST_ACQ) begin
                        if (match_cnt == MW'(LOCK_LEN - 1)) begin
                            state        <= ST_LOCKED;
                            bus.o_locked <= 1'b1;
                            match_cnt    <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                end else begin
                    state        <= ST_ACQ;
                    bus.o_locked <= 1'b0;
                    bus.o_err    <= 1'b1;
                    match_cnt    <= '0;
                    if (bus.o_err_cnt != '1)
                        bus.o_err_cnt <= bus.o_err_cnt + 1'b1;
                    if (!fail_seen) begin
                        fail_seen        <= 1'b1;
                        bus.o_first_fail <= exp_nxt;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ca_seq_checker.sv
// Randomized self-checking bench for ca_seq_checker against a cell-array reference model.
module tb_ca_seq_checker;
    localparam int AW      = 11;
    localparam int NW      = 10;
    localparam int LOC     = AW / 2;
    localparam int LL      = 16;
    localparam int RULE_TB = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model: explicit cell array plus the most recent tapped bits.
    bit   mgrid[AW];
    bit   taps[$];

    always #5 clk = ~clk;

    ca_seq_checker_if #(.ARRAY_WIDTH(AW), .N(NW)) bus();

    ca_seq_checker #(
        .ARRAY_WIDTH (AW),
        .RULE        (8'd30),
        .N           (NW),
        .LOCATION    (LOC),
        .LOCK_LEN    (LL)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    function automatic void model_start(input logic [AW-1:0] seed);
        for (int i = 0; i < AW; i++) mgrid[i] = seed[i];
        taps.delete();
    endfunction

    function automatic void model_step();
        bit nxt[AW];
        int sel;
        for (int i = 0; i < AW; i++) begin
            sel = 4 * int'(mgrid[(i + 1) % AW]) + 2 * int'(mgrid[i]) + int'(mgrid[(i + AW - 1) % AW]);
            nxt[i] = bit'((RULE_TB >> sel) & 1);
        end
        mgrid = nxt;
    endfunction

    // Returns the expected word for the next beat: bit j is the tap taken N-1-j beats earlier.
    function automatic logic [NW-1:0] model_next();
        logic [NW-1:0] e;
        int k, idx;
        taps.push_back(mgrid[LOC]);
        if (taps.size() > NW) void'(taps.pop_front());
        model_step();
        k = taps.size();
        e = '0;
        for (int j = 0; j < NW; j++) begin
            idx = k - NW + j;
            if (idx >= 0) e[j] = taps[idx];
        end
        return e;
    endfunction

    task automatic drive_start(input logic [AW-1:0] seed);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_seed  = seed;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic drive_beat(input logic [NW-1:0] rn);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_rn    = rn;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({bus.o_locked, bus.o_err, bus.o_err_cnt, bus.o_beat_cnt, bus.o_first_fail} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got lk=%0b err=%0b ec=%0h bc=%0h ff=%0h want all 0",
                     bus.o_locked, bus.o_err, bus.o_err_cnt, bus.o_beat_cnt, bus.o_first_fail);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive_beat(NW'($urandom));
        tests_run++;
        if (bus.o_beat_cnt !== 32'd0 || bus.o_err_cnt !== 16'd0 || bus.o_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_ignores_valid: got bc=%0h ec=%0h err=%0b want 0 0 0",
                     bus.o_beat_cnt, bus.o_err_cnt, bus.o_err);
        end
    endtask

    task automatic test_directed();
        logic [NW-1:0] words [3];
        words[0] = 10'b1000000000;
        words[1] = 10'b1100000000;
        words[2] = 10'b0110000000;
        drive_start(11'b00000100000);
        for (int i = 0; i < 3; i++) begin
            drive_beat(words[i]);
            tests_run++;
            if (bus.o_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed_err beat%0d: got %0b want 0", i + 1, bus.o_err);
            end
        end
        tests_run++;
        if (bus.o_err_cnt !== 16'd0 || bus.o_beat_cnt !== 32'd3) begin
            tests_failed++;
            $display("FAIL directed_counts: got ec=%0h bc=%0h want 0 3", bus.o_err_cnt, bus.o_beat_cnt);
        end
    endtask

    task automatic test_lock();
        logic [AW-1:0] seed;
        logic [NW-1:0] e, e20;
        seed = AW'($urandom) | 11'd1;
        model_start(seed);
        drive_start(seed);
        for (int b = 1; b <= 36; b++) begin
            e = model_next();
            if (b == 20) begin
                e20 = e;
                drive_beat(e ^ 10'd1);
                tests_run++;
                if (bus.o_err !== 1'b1 || bus.o_err_cnt !== 16'd1 || bus.o_first_fail !== e20 || bus.o_locked !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL lock_break: got err=%0b ec=%0h ff=%0h lk=%0b want 1 1 %0h 0",
                             bus.o_err, bus.o_err_cnt, bus.o_first_fail, bus.o_locked, e20);
                end
            end else begin
                drive_beat(e);
                tests_run++;
                if (bus.o_err !== 1'b0 || bus.o_locked !== ((b >= 16 && b < 20) || b == 36)) begin
                    tests_failed++;
                    $display("FAIL lock_track beat%0d: got err=%0b lk=%0b want 0 %0b", b, bus.o_err,
                             bus.o_locked, (b >= 16 && b < 20) || b == 36);
                end
            end
        end
        tests_run++;
        if (bus.o_beat_cnt !== 32'd36 || bus.o_err_cnt !== 16'd1 || bus.o_first_fail !== e20) begin
            tests_failed++;
            $display("FAIL lock_counts: got bc=%0h ec=%0h ff=%0h want 24 1 %0h",
                     bus.o_beat_cnt, bus.o_err_cnt, bus.o_first_fail, e20);
        end
        drive_start(AW'($urandom));
        tests_run++;
        if (bus.o_locked !== 1'b0 || bus.o_err_cnt !== 16'd0 || bus.o_beat_cnt !== 32'd0 || bus.o_first_fail !== '0) begin
            tests_failed++;
            $display("FAIL start_while_locked: got lk=%0b ec=%0h bc=%0h ff=%0h want all 0",
                     bus.o_locked, bus.o_err_cnt, bus.o_beat_cnt, bus.o_first_fail);
        end
    endtask

    task automatic test_start_with_valid();
        logic [AW-1:0] seed;
        seed = AW'($urandom) | 11'd2;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_seed  = seed;
        bus.i_rn    = NW'($urandom);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        model_start(seed);
        tests_run++;
        if (bus.o_beat_cnt !== 32'd0 || bus.o_err !== 1'b0 || bus.o_err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL start_valid_discard: got bc=%0h err=%0b ec=%0h want 0 0 0",
                     bus.o_beat_cnt, bus.o_err, bus.o_err_cnt);
        end
        for (int b = 1; b <= 2; b++) begin
            drive_beat(model_next());
            tests_run++;
            if (bus.o_err !== 1'b0 || bus.o_beat_cnt !== 32'(b)) begin
                tests_failed++;
                $display("FAIL start_valid_followup beat%0d: got err=%0b bc=%0h want 0 %0h",
                         b, bus.o_err, bus.o_beat_cnt, b);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] seed;
        logic [NW-1:0] e, ff;
        bit bad, seen;
        int run, errs, beats;
        seed = AW'($urandom);
        model_start(seed);
        drive_start(seed);
        run = 0; errs = 0; beats = 0; seen = 0; ff = '0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(4) == 0) begin
                @(negedge clk);
                bus.i_rn = NW'($urandom);
                @(posedge clk);
                #1;
                tests_run++;
                if (bus.o_err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL random_gap_err step%0d: got %0b want 0", i, bus.o_err);
                end
            end
            e = model_next();
            bad = ($urandom_range(15) == 0);
            beats++;
            if (bad) begin
                drive_beat(e ^ NW'($urandom_range(1, (1 << NW) - 1)));
                errs++;
                run = 0;
                if (!seen) begin seen = 1; ff = e; end
            end else begin
                drive_beat(e);
                run++;
            end
            tests_run++;
            if (bus.o_err !== bad || bus.o_locked !== (run >= LL)) begin
                tests_failed++;
                $display("FAIL random_beat%0d: got err=%0b lk=%0b want %0b %0b",
                         beats, bus.o_err, bus.o_locked, bad, run >= LL);
            end
        end
        tests_run++;
        if (bus.o_err_cnt !== 16'(errs) || bus.o_beat_cnt !== 32'(beats) || bus.o_first_fail !== ff) begin
            tests_failed++;
            $display("FAIL random_totals: got ec=%0h bc=%0h ff=%0h want %0h %0h %0h",
                     bus.o_err_cnt, bus.o_beat_cnt, bus.o_first_fail, errs, beats, ff);
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] seed;
        logic [NW-1:0] e;
        seed = AW'($urandom) | 11'd4;
        model_start(seed);
        drive_start(seed);
        for (int b = 1; b <= 29; b++) begin
            e = model_next();
            drive_beat(b == 3 ? (e ^ 10'h200) : e);
        end
        tests_run++;
        if (bus.o_locked !== 1'b1 || bus.o_err_cnt !== 16'd1 || bus.o_beat_cnt !== 32'd29) begin
            tests_failed++;
            $display("FAIL pre_reset_state: got lk=%0b ec=%0h bc=%0h want 1 1 1d",
                     bus.o_locked, bus.o_err_cnt, bus.o_beat_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.o_locked, bus.o_err, bus.o_err_cnt, bus.o_beat_cnt, bus.o_first_fail} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got lk=%0b err=%0b ec=%0h bc=%0h ff=%0h want all 0",
                     bus.o_locked, bus.o_err, bus.o_err_cnt, bus.o_beat_cnt, bus.o_first_fail);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive_beat(NW'($urandom));
        tests_run++;
        if (bus.o_beat_cnt !== 32'd0 || bus.o_err_cnt !== 16'd0 || bus.o_locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got bc=%0h ec=%0h lk=%0b want 0 0 0",
                     bus.o_beat_cnt, bus.o_err_cnt, bus.o_locked);
        end
        model_start(seed);
        drive_start(seed);
        drive_beat(model_next());
        tests_run++;
        if (bus.o_beat_cnt !== 32'd1 || bus.o_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_restart: got bc=%0h err=%0b want 1 0", bus.o_beat_cnt, bus.o_err);
        end
    endtask

    task automatic test_saturation();
        logic [AW-1:0] seed;
        seed = AW'($urandom);
        model_start(seed);
        drive_start(seed);
        for (int b = 1; b <= 70000; b++) begin
            drive_beat(model_next() ^ 10'd1);
            if (b == 65534 || b == 65535) begin
                tests_run++;
                if (bus.o_err_cnt !== 16'(b)) begin
                    tests_failed++;
                    $display("FAIL sat_approach beat%0d: got %0h want %0h", b, bus.o_err_cnt, b);
                end
            end
        end
        tests_run++;
        if (bus.o_err_cnt !== 16'hFFFF || bus.o_beat_cnt !== 32'd70000 || bus.o_err !== 1'b1 || bus.o_locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_hold: got ec=%0h bc=%0h err=%0b lk=%0b want ffff 11170 1 0",
                     bus.o_err_cnt, bus.o_beat_cnt, bus.o_err, bus.o_locked);
        end
    endtask

    initial begin
        bus.i_seed  = '0;
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_rn    = '0;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_directed();
        test_lock();
        test_start_with_valid();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
